// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
// Subtraction support is compiled in only when SERIAL_ADDER_SUB_EN is defined.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   // Counter must be able to represent WIDTH itself, hence the +1.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// One-bit full-adder slice; the only arithmetic in the serial adder.
module serial_adder_slice (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock, ARM-style NZCV flags.
// Define SERIAL_ADDER_SUB_EN to enable A-B via the sub input; otherwise every op is A+B.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_word;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             carry_init;
   logic             b_bit;
   logic             sum_bit;
   logic             carry_out;
   logic             last_bit;
   logic             load;
   flags_t           flags;

`ifdef SERIAL_ADDER_SUB_EN
   logic sub_q;

   // Two's-complement subtract: invert B and inject 1 as the initial carry.
   assign b_bit      = b_sh[0] ^ sub_q;
   assign carry_init = sub;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         sub_q <= 1'b0;
      else if (load)
         sub_q <= sub;
   end
`else
   logic unused_sub;

   assign b_bit      = b_sh[0];
   assign carry_init = 1'b0;
   assign unused_sub = sub;
`endif

   serial_adder_slice u_slice (
      .x    (a_sh[0]),
      .y    (b_bit),
      .cin  (carry),
      .s    (sum_bit),
      .cout (carry_out)
   );

   // Sum bits enter at the top of the A register as operand bits leave the bottom.
   assign sum_word = {sum_bit, a_sh[WIDTH-1:1]};
   assign last_bit = (cnt == LAST);
   assign load     = start && (state != RUN);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_sh   <= '0;
         b_sh   <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         result <= '0;
         flags  <= '0;
      end else if (load) begin
         a_sh  <= a;
         b_sh  <= b;
         cnt   <= '0;
         carry <= carry_init;
      end else if (state == RUN) begin
         a_sh  <= sum_word;
         b_sh  <= b_sh >> 1;
         carry <= carry_out;
         cnt   <= cnt + CW'(1);
         if (last_bit) begin
            result <= sum_word;
            // carry still holds the carry into the MSB on this cycle.
            flags  <= '{n: sum_bit, z: (sum_word == '0), c: carry_out, v: carry ^ carry_out};
         end
      end
   end

   assign flag_n = flags.n;
   assign flag_z = flags.z;
   assign flag_c = flags.c;
   assign flag_v = flags.v;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results, a negedge monitor checks them.
// Expectations follow SERIAL_ADDER_SUB_EN the same way the design build does.
module tb_serial_adder;

   localparam int W = 64;
`ifdef SERIAL_ADDER_SUB_EN
   localparam logic SUB_EN = 1'b1;
`else
   localparam logic SUB_EN = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] r;
      logic [3:0]   f;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, flag_n, flag_z, flag_c, flag_v;
   logic [W-1:0] result;

   exp_t q[$];
   exp_t last = '{r: '0, f: '0, due: 0};
   int   compared = 0;
   int   mismatched = 0;
   int   ncyc = 0;
   int   last_due = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .sub    (sub),
      .busy   (busy),
      .done   (done),
      .result (result),
      .flag_n (flag_n),
      .flag_z (flag_z),
      .flag_c (flag_c),
      .flag_v (flag_v)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, ncyc, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic; V from true signed range, C from unsigned carry/borrow.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t               m;
      logic               eff, c, v;
      logic [W:0]         u;
      logic signed [W+1:0] sx, sy, t;
      eff = s & SUB_EN;
      sx  = $signed({{2{x[W-1]}}, x});
      sy  = $signed({{2{y[W-1]}}, y});
      if (eff) begin
         u = {1'b0, x} - {1'b0, y};
         c = (x >= y);
         t = sx - sy;
      end else begin
         u = {1'b0, x} + {1'b0, y};
         c = u[W];
         t = sx + sy;
      end
      v     = !((t[W+1:W-1] == 3'b000) || (t[W+1:W-1] == 3'b111));
      m.r   = u[W-1:0];
      m.f   = {u[W-1], (u[W-1:0] == '0), c, v};
      m.due = 0;
      return m;
   endfunction

   function automatic logic [W-1:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Issue one operation; now=1 means the caller is already inside the DONE cycle.
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [W-1:0] er, input logic [3:0] ef, input bit now);
      exp_t e;
      if (!now) @(negedge clk);
      #1;
      start = 1'b1;
      a     = x;
      b     = y;
      sub   = s;
      e.r   = er;
      e.f   = ef;
      e.due = ncyc + W + 1;
      q.push_back(e);
      last_due = e.due;
      @(negedge clk);
      #1;
      start = 1'b0;
      a     = {$urandom, $urandom};
      b     = {$urandom, $urandom};
      sub   = $urandom_range(0, 1) == 1;
   endtask

   task automatic wait_due();
      wait (ncyc == last_due);
   endtask

   task automatic rand_op(input bit now);
      logic [W-1:0] x, y;
      logic         s;
      exp_t         m;
      x = rand_word();
      y = rand_word();
      s = $urandom_range(0, 1) == 1;
      m = model(x, y, s);
      do_op(x, y, s, m.r, m.f, now);
   endtask

   // Monitor: busy window, done timing, and result/flags hold-or-update every cycle.
   always @(negedge clk) begin
      logic exp_busy, exp_done;
      ncyc++;
      exp_busy = (q.size() > 0) && (ncyc >= q[0].due - W) && (ncyc < q[0].due);
      exp_done = (q.size() > 0) && (ncyc == q[0].due);
      check("busy", W'(busy), W'(exp_busy));
      check("done", W'(done), W'(exp_done));
      if (exp_done) last = q.pop_front();
      check("result", result, last.r);
      check("flags_nzcv", W'({flag_n, flag_z, flag_c, flag_v}), W'(last.f));
   end

   initial begin
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;

      do_op(64'd1, 64'd1, 1'b0, 64'd2, 4'b0000, 1'b0);
      wait_due();
      do_op('1, 64'd1, 1'b0, 64'd0, 4'b0110, 1'b0);
      wait_due();
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001, 1'b0);
      wait_due();
`ifdef SERIAL_ADDER_SUB_EN
      do_op(64'd5, 64'd5, 1'b1, 64'd0, 4'b0110, 1'b1);
      wait_due();
      do_op(64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b1);
      wait_due();
`else
      do_op(64'd5, 64'd5, 1'b1, 64'd10, 4'b0000, 1'b1);
      wait_due();
      do_op(64'd3, 64'd5, 1'b1, 64'd8, 4'b0000, 1'b1);
      wait_due();
`endif

      // A start pulse mid-run must be ignored; start held in DONE chains a new op.
      do_op(64'd1, 64'd2, 1'b0, 64'd3, 4'b0000, 1'b0);
      wait (ncyc == last_due - 40);
      #1;
      start = 1'b1;
      a     = 64'd10;
      b     = 64'd20;
      @(negedge clk);
      #1 start = 1'b0;
      wait_due();
      rand_op(1'b1);
      wait_due();

      // Asynchronous reset at run cycle 30 aborts the op with no done pulse.
      rand_op(1'b0);
      wait (ncyc == last_due - (W + 1) + 30);
      #2 reset = 1'b0;
      #1;
      check("reset_busy", W'(busy), '0);
      check("reset_done", W'(done), '0);
      check("reset_result", result, '0);
      check("reset_flags", W'({flag_n, flag_z, flag_c, flag_v}), '0);
      q.delete();
      last = '{r: '0, f: '0, due: 0};
      @(negedge clk);
      #2 reset = 1'b1;
      rand_op(1'b0);
      wait_due();

      for (int i = 0; i < 16; i++) begin
         rand_op($urandom_range(0, 1) == 1);
         wait_due();
      end

      for (int g = 0; g < 200 && q.size() > 0; g++) @(negedge clk);
      check("drain_queue_empty", W'(q.size()), '0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 64, operand/result width in bits (>=2).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL have port: start  input  1  request new operation; sampled on rising clk edge.
REQ-005 SHALL have port: a  input  WIDTH  operand A; captured with start.
REQ-006 SHALL have port: b  input  WIDTH  operand B; captured with start.
REQ-007 SHALL have port: sub  input  1  1 = A-B, 0 = A+B; captured with start.
REQ-008 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; result/flags valid.
REQ-010 SHALL have port: result  output  WIDTH  sum/difference.
REQ-011 SHALL have ports: flag_n, flag_z, flag_c, flag_v  output  1 each  ARM-style negative, zero, carry, overflow.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE or DONE with start=1 at an edge SHALL capture a, b, sub, clear bit counter, load carry = sub, enter RUN.
REQ-014 RUN SHALL process one bit per cycle, LSB first, through a 1-bit full-adder slice (b bit inverted when sub=1), shifting sum bit into result MSB-side shift register.
REQ-015 RUN SHALL last exactly WIDTH cycles, then enter DONE; DONE SHALL last one cycle, then IDLE unless start=1 (back-to-back accepted).
REQ-016 done SHALL be high only in DONE, i.e. exactly WIDTH+1 edges after the start-sampling edge.
REQ-017 busy SHALL be high in RUN only.
REQ-018 start while RUN SHALL be ignored; operands SHALL not change mid-operation.
REQ-019 result and flags SHALL update only on entry to DONE and hold until next entry to DONE; during RUN they SHALL keep previous values.
REQ-020 flag_n = result MSB; flag_z = 1 iff result == 0; flag_c = carry out of MSB (for sub: 1 = no borrow); flag_v = carry into MSB XOR carry out of MSB.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; carry out not folded into result.

Reset
REQ-022 reset=0 SHALL asynchronously force IDLE, busy=0, done=0, result=0, all flags=0, counter=0, carry=0.
REQ-023 reset asserted during RUN SHALL abort the operation with no done pulse; first start after release begins fresh.

Configuration
REQ-024 Macro SERIAL_ADDER_SUB_EN defined: sub behaves per REQ-007/013/014.
REQ-025 Macro SERIAL_ADDER_SUB_EN undefined: sub port present but ignored; initial carry = 0, b never inverted; all operations are A+B.

Structure
REQ-026 Package serial_adder_pkg SHALL hold state enum type (IDLE/RUN/DONE), default width constant, and a packed flags struct {n,z,c,v}.
REQ-027 Bit counter width SHALL be $clog2(WIDTH+1), derived in package function or local constant.
REQ-028 Sub-module serial_adder_slice (combinational 1-bit sum/carry) SHALL be the only arithmetic; instantiated once.

Verification (WIDTH=64, macro defined unless stated)
REQ-029 a=1, b=1, sub=0, start one cycle -> done exactly 65 edges later, result=2, n=z=c=v=0; busy high 64 cycles.
REQ-030 a=0xFFFF_FFFF_FFFF_FFFF, b=1, add -> result=0, z=1, c=1, n=0, v=0.
REQ-031 a=0x7FFF_FFFF_FFFF_FFFF, b=1, add -> result=0x8000_0000_0000_0000, n=1, v=1, c=0; then sub a=5, b=5 -> result=0, z=1, c=1; sub a=3, b=5 -> result=0xFFFF_FFFF_FFFF_FFFE, n=1, c=0.
REQ-032 start with a=10, b=20 during RUN of a=1, b=2 -> ignored, single done, result=3; start held high in DONE -> second op begins, done again 65 edges later.
REQ-033 reset=0 at RUN cycle 30 -> busy/done/result/flags 0 immediately (async), no done pulse; new op after release correct.
REQ-034 Macro undefined: sub=1, a=5, b=5 -> result=10, c=0, z=0.
